y86_imem_fetch: RTL and testbench

Instruction-memory side of the fetch interface. It accepts a byte PC, reads aligned 32-bit words from instruction memory over a req/ack handshake, and assembles the INST_BYTES-byte instruction window starting at that PC. It returns the window on the instruction bus consumed by the fetch/decode stage. One fetch is in flight at a time, with ready/valid on both the PC side and the instruction side.

---
 rtl/y86_imem_fetch.sv | 116 +++++++++++
 tb/tb_y86_imem_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/y86_imem_fetch.sv
// Instruction fetch window assembler: reads aligned 32-bit words over req/ack and
// returns the INST_BYTES-byte window starting at an arbitrary byte PC.
module y86_imem_fetch #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned INST_BYTES = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       pc_i,
    input  logic                    pc_valid_i,
    output logic                    pc_ready_o,
    input  logic                    flush_i,
    output logic [ADDR_W-1:0]       mem_addr_o,
    output logic                    mem_req_o,
    input  logic                    mem_ack_i,
    input  logic [31:0]             mem_rdata_i,
    input  logic                    mem_err_i,
    output logic [8*INST_BYTES-1:0] inst_o,
    output logic [ADDR_W-1:0]       inst_pc_o,
    output logic                    inst_valid_o,
    input  logic                    inst_ready_i,
    output logic                    inst_err_o
);

    // Worst case is offset 3, so the window can straddle up to this many words.
    localparam int unsigned MaxWords = (INST_BYTES + 6) / 4;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StOut   = 2'd3;

    logic [1:0]            state_q;
    logic [1:0]            cnt_q;
    logic [1:0]            nwords_q;
    logic [ADDR_W-1:0]     pc_q;
    logic [32*MaxWords-1:0] buf_q;
    logic                  err_q;

    logic                  accept;
    logic                  last_word;
    logic [3:0]            span;
    logic [ADDR_W-1:0]     base;

    assign pc_ready_o = (state_q == StIdle) && !flush_i && !rst;
    assign accept     = pc_valid_i && pc_ready_o;
    assign last_word  = (cnt_q == nwords_q - 2'd1);
    assign span       = 4'(pc_i[1:0]) + 4'(INST_BYTES + 3);
    assign base       = {pc_q[ADDR_W-1:2], 2'b00};

    assign mem_req_o    = (state_q == StFetch) || (state_q == StDrain);
    assign mem_addr_o   = mem_req_o ? base + ADDR_W'({cnt_q, 2'b00}) : '0;
    assign inst_pc_o    = pc_q;
    assign inst_valid_o = (state_q == StOut);
    assign inst_err_o   = (state_q == StOut) && err_q;

    // Byte pc+k sits at buffer byte off+k and lands MSB-first on the bus.
    always_comb begin
        inst_o = '0;
        for (int k = 0; k < int'(INST_BYTES); k++) begin
            inst_o[8*(int'(INST_BYTES)-1-k) +: 8] = buf_q[8*(int'(pc_q[1:0])+k) +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            nwords_q <= '0;
            pc_q     <= '0;
            buf_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pc_q     <= pc_i;
                        nwords_q <= span[3:2];
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (flush_i) begin
                        state_q <= mem_ack_i ? StIdle : StDrain;
                    end else if (mem_ack_i) begin
                        for (int w = 0; w < int'(MaxWords); w++) begin
                            if (int'(cnt_q) == w) begin
                                buf_q[32*w +: 32] <= mem_rdata_i;
                            end
                        end
                        err_q <= err_q | mem_err_i;
                        if (last_word) begin
                            state_q <= StOut;
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                StDrain: begin
                    if (mem_ack_i) begin
                        state_q <= StIdle;
                    end
                end
                StOut: begin
                    if (flush_i || inst_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_imem_fetch.sv
// Directed bench for y86_imem_fetch: memory byte at address a holds a[7:0].
module tb_y86_imem_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic [31:0] mem_addr_o;
    logic        mem_req_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        mem_err_i;
    logic [47:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        inst_err_o;

    int tests = 0;
    int fails = 0;

    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = '0;

    always #5 clk = ~clk;

    y86_imem_fetch #(.ADDR_W(32), .INST_BYTES(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .mem_addr_o   (mem_addr_o),
        .mem_req_o    (mem_req_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_err_o   (inst_err_o)
    );

    // Memory model: combinational data, ack after ack_delay waiting cycles.
    assign mem_ack_i   = mem_req_o && (wait_cnt >= ack_delay);
    assign mem_rdata_i = {mem_addr_o[7:0] + 8'd3, mem_addr_o[7:0] + 8'd2,
                          mem_addr_o[7:0] + 8'd1, mem_addr_o[7:0]};
    assign mem_err_i   = mem_req_o && err_en && (mem_addr_o == err_addr);

    always @(posedge clk) begin
        if (rst || !mem_req_o || mem_ack_i) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (inst_valid_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("valid_timeout", {63'd0, inst_valid_o}, 64'd1);
    endtask

    task automatic issue_pc(input logic [31:0] pc);
        pc_i       = pc;
        pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0;
    endtask

    initial begin
        logic [47:0] held;
        rst = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; inst_ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid",   {63'd0, inst_valid_o}, 64'd0);
        chk("rst_req",     {63'd0, mem_req_o},    64'd0);
        chk("rst_addr",    {32'd0, mem_addr_o},   64'd0);
        chk("rst_inst",    {16'd0, inst_o},       64'd0);
        chk("rst_pc",      {32'd0, inst_pc_o},    64'd0);
        chk("rst_err",     {63'd0, inst_err_o},   64'd0);
        chk("rst_pcready", {63'd0, pc_ready_o},   64'd0);
        rst = 1'b0;
        #1;
        chk("idle_pcready", {63'd0, pc_ready_o}, 64'd1);

        // Basic aligned fetch, ack tied high
        issue_pc(32'h10);
        chk("t1_req0",  {63'd0, mem_req_o},  64'd1);
        chk("t1_addr0", {32'd0, mem_addr_o}, 64'h10);
        chk("t1_busy",  {63'd0, pc_ready_o}, 64'd0);
        tick();
        chk("t1_addr1", {32'd0, mem_addr_o}, 64'h14);
        tick();
        chk("t1_valid", {63'd0, inst_valid_o}, 64'd1);
        chk("t1_inst",  {16'd0, inst_o},       64'h101112131415);
        chk("t1_pc",    {32'd0, inst_pc_o},    64'h10);
        chk("t1_err",   {63'd0, inst_err_o},   64'd0);
        chk("t1_noreq", {63'd0, mem_req_o},    64'd0);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("t1_done", {63'd0, inst_valid_o}, 64'd0);

        // Unaligned window spanning three words
        issue_pc(32'h03);
        chk("t2_addr0", {32'd0, mem_addr_o}, 64'h0);
        tick();
        chk("t2_addr1", {32'd0, mem_addr_o}, 64'h4);
        tick();
        chk("t2_addr2", {32'd0, mem_addr_o}, 64'h8);
        tick();
        chk("t2_valid", {63'd0, inst_valid_o}, 64'd1);
        chk("t2_inst",  {16'd0, inst_o},       64'h030405060708);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;

        // Slow memory and consumer backpressure
        ack_delay = 3;
        issue_pc(32'h41);
        for (int i = 0; i < 4; i++) begin
            chk("t3_addr0", {32'd0, mem_addr_o}, 64'h40);
            chk("t3_busy",  {63'd0, pc_ready_o}, 64'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_addr1", {32'd0, mem_addr_o}, 64'h44);
            tick();
        end
        chk("t3_valid", {63'd0, inst_valid_o}, 64'd1);
        held = 48'h414243444546;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", {63'd0, inst_valid_o}, 64'd1);
            chk("t3_hold_inst",  {16'd0, inst_o},       {16'd0, held});
            chk("t3_hold_busy",  {63'd0, pc_ready_o},   64'd0);
            tick();
        end
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("t3_done", {63'd0, inst_valid_o}, 64'd0);

        // Flush while word 0 is waiting for its ack
        ack_delay = 2;
        issue_pc(32'h30);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t4_drain_req",  {63'd0, mem_req_o},    64'd1);
        chk("t4_drain_addr", {32'd0, mem_addr_o},   64'h30);
        chk("t4_drain_busy", {63'd0, pc_ready_o},   64'd0);
        tick();
        chk("t4_ack",        {63'd0, mem_ack_i},    64'd1);
        chk("t4_ack_addr",   {32'd0, mem_addr_o},   64'h30);
        chk("t4_novalid",    {63'd0, inst_valid_o}, 64'd0);
        tick();
        chk("t4_idle_req",   {63'd0, mem_req_o},    64'd0);
        chk("t4_idle_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("t4_idle_ready", {63'd0, pc_ready_o},   64'd1);
        ack_delay = 0;
        issue_pc(32'h20);
        wait_valid(10);
        chk("t4_inst", {16'd0, inst_o}, 64'h202122232425);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;

        // Address wrap with an error on the word at 0
        err_en = 1'b1; err_addr = 32'h0;
        issue_pc(32'hFFFF_FFFF);
        chk("t5_addr0", {32'd0, mem_addr_o}, 64'hFFFF_FFFC);
        tick();
        chk("t5_addr1", {32'd0, mem_addr_o}, 64'h0);
        tick();
        chk("t5_addr2", {32'd0, mem_addr_o}, 64'h4);
        tick();
        chk("t5_valid", {63'd0, inst_valid_o}, 64'd1);
        chk("t5_err",   {63'd0, inst_err_o},   64'd1);
        chk("t5_inst",  {16'd0, inst_o},       64'hFF0001020304);
        chk("t5_pc",    {32'd0, inst_pc_o},    64'hFFFF_FFFF);
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        err_en = 1'b0;

        // Reset while presenting a window
        issue_pc(32'h50);
        wait_valid(10);
        rst = 1'b1;
        tick();
        chk("t6a_valid", {63'd0, inst_valid_o}, 64'd0);
        chk("t6a_req",   {63'd0, mem_req_o},    64'd0);
        rst = 1'b0;

        // Flush racing inst_ready_i in OUT
        issue_pc(32'h60);
        wait_valid(10);
        chk("t6b_inst", {16'd0, inst_o}, 64'h606162636465);
        flush_i = 1'b1; inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        chk("t6b_valid",      {63'd0, inst_valid_o}, 64'd0);
        chk("t6b_flush_rdy",  {63'd0, pc_ready_o},   64'd0);
        // Flush in IDLE blocks a simultaneous PC
        pc_i = 32'h70; pc_valid_i = 1'b1;
        tick();
        pc_valid_i = 1'b0; flush_i = 1'b0;
        chk("t6b_no_accept", {63'd0, mem_req_o},    64'd0);
        chk("t6b_no_dup",    {63'd0, inst_valid_o}, 64'd0);
        #1;
        chk("t6b_idle_rdy",  {63'd0, pc_ready_o},   64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
